// File: rtl/ram_sp_ctrl.sv
// ram_sp_ctrl: parametrised single-port synchronous RAM with a request/ready
// front end, per-byte write enables, registered read with valid strobe and a
// built-in clear engine that fills every word with INIT_VAL after reset or on
// a clr command.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   clr       start a clear of the whole array (sampled while ready=1)
//   req       access request
//   we        1 = write, 0 = read (qualified by req)
//   be        per-byte write enables (bit i -> data bits [8i+7:8i])
//   addr      word address
//   data_in   write data
//   ready     block accepts a request this cycle
//   data_out  read data, held between reads
//   rd_valid  one-cycle pulse: data_out carries new read data
//   err       one-cycle pulse: accepted request had addr >= DEPTH
module ram_sp_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 4,
  parameter int                DEPTH    = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  ready,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int          CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [DATA_W-1:0]   r_data_out;
  logic                r_rd_valid;
  logic                r_err;

  logic                w_accept;
  logic                w_in_range;
  logic [CNT_W-1:0]    w_idx;
  logic                w_mem_we;
  logic [CNT_W-1:0]    w_mem_idx;
  logic [NB-1:0]       w_mem_be;
  logic [DATA_W-1:0]   w_mem_wdata;

  assign w_in_range = (32'(addr) < 32'(DEPTH));
  // Out-of-range addresses never reach the array; park the index at 0.
  assign w_idx      = w_in_range ? CNT_W'(addr) : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // Output / datapath control
  always_comb begin
    ready       = 1'b0;
    w_accept    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_idx   = '0;
    w_mem_be    = '0;
    w_mem_wdata = '0;
    case (r_state)
      ST_INIT: begin
        // Gated by rst_n so a held reset does not keep writing word 0.
        w_mem_we    = rst_n;
        w_mem_idx   = r_cnt;
        w_mem_be    = '1;
        w_mem_wdata = INIT_VAL;
      end
      ST_IDLE: begin
        ready    = 1'b1;
        // clr wins over a simultaneous request.
        w_accept = req & ~clr;
        if (w_accept && we && w_in_range) begin
          w_mem_we    = 1'b1;
          w_mem_idx   = w_idx;
          w_mem_be    = be;
          w_mem_wdata = data_in;
        end
      end
    endcase
  end

  // Array: not reset, the clear engine overwrites it.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (w_mem_be[i]) begin
          r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read port and status strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= w_accept & ~we;
      r_err      <= w_accept & ~w_in_range;
      if (w_accept && !we) begin
        r_data_out <= w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;
  assign err      = r_err;

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// tb_ram_sp_ctrl: directed bench for ram_sp_ctrl using three instances:
// defaults (8x16), a 32-bit wide one with a non-zero INIT_VAL, and a 12-deep
// one for out-of-range handling. Inputs other than req/clr are shared.
module tb_ram_sp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr8 = 1'b0;
  logic        clr12 = 1'b0;
  logic        clr32 = 1'b0;
  logic        req8 = 1'b0;
  logic        req12 = 1'b0;
  logic        req32 = 1'b0;
  logic        we_s = 1'b0;
  logic [3:0]  be_s = '0;
  logic [3:0]  addr_s = '0;
  logic [31:0] data_s = '0;

  logic        ready8, rv8, err8;
  logic [7:0]  dout8;
  logic        ready12, rv12, err12;
  logic [7:0]  dout12;
  logic        ready32, rv32, err32;
  logic [31:0] dout32;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_sp_ctrl u_dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8), .req(req8), .we(we_s),
    .be(be_s[0]), .addr(addr_s), .data_in(data_s[7:0]),
    .ready(ready8), .data_out(dout8), .rd_valid(rv8), .err(err8)
  );

  ram_sp_ctrl #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_VAL(8'h00)
  ) u_dut12 (
    .clk(clk), .rst_n(rst_n), .clr(clr12), .req(req12), .we(we_s),
    .be(be_s[0]), .addr(addr_s), .data_in(data_s[7:0]),
    .ready(ready12), .data_out(dout12), .rd_valid(rv12), .err(err12)
  );

  ram_sp_ctrl #(
    .DATA_W(32), .ADDR_W(4), .DEPTH(16), .INIT_VAL(32'hDEADBEEF)
  ) u_dut32 (
    .clk(clk), .rst_n(rst_n), .clr(clr32), .req(req32), .we(we_s),
    .be(be_s), .addr(addr_s), .data_in(data_s),
    .ready(ready32), .data_out(dout32), .rd_valid(rv32), .err(err32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request on the chosen unit from a negedge; returns at the
  // following negedge, where the response of that request is visible.
  task automatic acc(input int unit, input logic w, input logic [3:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    we_s   = w;
    addr_s = a;
    data_s = d;
    be_s   = b;
    req8   = (unit == 8);
    req12  = (unit == 12);
    req32  = (unit == 32);
    @(negedge clk);
    req8  = 1'b0;
    req12 = 1'b0;
    req32 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c8, c12, c32, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", ready8, 0);
    check("rst_rv", rv8, 0);
    check("rst_err", err8, 0);
    check("rst_dout", dout8, 0);

    // Clear duration after reset release
    rst_n = 1'b1;
    c8 = 0; c12 = 0; c32 = 0;
    repeat (30) begin
      if (!ready8)  c8++;
      if (!ready12) c12++;
      if (!ready32) c32++;
      @(negedge clk);
    end
    check("init_len8", c8, 16);
    check("init_len12", c12, 12);
    check("init_len32", c32, 16);

    // Back-to-back reads of every address
    we_s = 1'b0; be_s = '0; addr_s = 4'd0; req8 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("b2b_rv", rv8, 1);
      check("b2b_dout", dout8, 0);
      if (i < 16) addr_s = 4'(i);
      else        req8 = 1'b0;
    end
    @(negedge clk);
    check("b2b_rv_end", rv8, 0);

    // Write then read-after-write
    acc(8, 1, 4'd1, 32'hAA, 4'h1);
    check("wr_rv", rv8, 0);
    check("wr_err", err8, 0);
    acc(8, 0, 4'd1, 0, 0);
    check("raw_rv", rv8, 1);
    check("raw_dout", dout8, 32'hAA);
    acc(8, 0, 4'd2, 0, 0);
    check("rd2_dout", dout8, 0);
    // be=0 write is a no-op
    acc(8, 1, 4'd1, 32'h00, 4'h0);
    acc(8, 0, 4'd1, 0, 0);
    check("be0_dout", dout8, 32'hAA);
    @(negedge clk);
    check("hold_rv", rv8, 0);
    check("hold_dout", dout8, 32'hAA);

    // 32-bit byte enables and INIT_VAL
    acc(32, 1, 4'd3, 32'h11223344, 4'hF);
    acc(32, 1, 4'd3, 32'hFFFFFFFF, 4'h5);
    acc(32, 0, 4'd3, 0, 0);
    check("be32_rv", rv32, 1);
    check("be32_dout", dout32, 32'h11FF33FF);
    acc(32, 0, 4'd0, 0, 0);
    check("init32_a0", dout32, 32'hDEADBEEF);
    acc(32, 0, 4'd15, 0, 0);
    check("init32_a15", dout32, 32'hDEADBEEF);

    // Out-of-range on DEPTH=12
    acc(12, 1, 4'd11, 32'h3C, 4'h1);
    check("d12_wr11_err", err12, 0);
    acc(12, 0, 4'd11, 0, 0);
    check("d12_rd11", dout12, 32'h3C);
    check("d12_rd11_err", err12, 0);
    acc(12, 1, 4'd13, 32'h55, 4'h1);
    check("oor_wr_err", err12, 1);
    check("oor_wr_rv", rv12, 0);
    acc(12, 0, 4'd13, 0, 0);
    check("oor_rd_rv", rv12, 1);
    check("oor_rd_dout", dout12, 0);
    check("oor_rd_err", err12, 1);
    acc(12, 0, 4'd11, 0, 0);
    check("d12_rd11b", dout12, 32'h3C);
    acc(12, 0, 4'd1, 0, 0);
    check("d12_rd1", dout12, 0);
    check("d12_rd1_err", err12, 0);

    // clr with simultaneous read; clr during INIT is ignored
    acc(8, 1, 4'd7, 32'h5A, 4'h1);
    acc(8, 0, 4'd7, 0, 0);
    check("pre_clr", dout8, 32'h5A);
    we_s = 1'b0; addr_s = 4'd7; clr8 = 1'b1; req8 = 1'b1;
    @(negedge clk);
    req8 = 1'b0;
    check("clr_rv", rv8, 0);
    check("clr_ready", ready8, 0);
    n = 0;
    while (!ready8 && n < 100) begin
      clr8 = (n < 3);
      n++;
      @(negedge clk);
    end
    clr8 = 1'b0;
    check("clr_len", n, 16);
    acc(8, 0, 4'd7, 0, 0);
    check("clr_rd7", dout8, 0);

    // Reset pulse at INIT counter=8
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    c8 = 0; c12 = 0;
    repeat (30) begin
      if (!ready8)  c8++;
      if (!ready12) c12++;
      @(negedge clk);
    end
    check("midinit_len8", c8, 16);
    check("midinit_len12", c12, 12);

    // Reset right after a read is accepted
    acc(8, 1, 4'd4, 32'h77, 4'h1);
    acc(8, 0, 4'd4, 0, 0);
    check("pre_rst_rd", dout8, 32'h77);
    we_s = 1'b0; addr_s = 4'd4; req8 = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_rd_rv", rv8, 0);
    check("rst_rd_dout", dout8, 0);
    @(negedge clk);
    req8 = 1'b0;
    check("rst_rd_rv2", rv8, 0);
    rst_n = 1'b1;
    n = 0;
    while (!ready8 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("rst_rd_len", n, 16);
    acc(8, 0, 4'd4, 0, 0);
    check("post_rst_rv", rv8, 1);
    check("post_rst_rd4", dout8, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
